// File: rtl/instr_sequencer.sv
// Instruction fetch/decode/dispatch controller: walks instruction memory from word 0 and hands each
// word to the matrix or integer ALU. Defining SEQ_TIMEOUT_EN adds a WAIT-state watchdog and the Timeout port.
module instr_sequencer #(
    parameter logic [3:0] INSTR_MEM_EN = 4'h2,
    parameter int         INSTR_DEPTH  = 12
`ifdef SEQ_TIMEOUT_EN
    , parameter int       TIMEOUT_CYCLES = 256
`endif
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    output logic [15:0] Address,
    output logic        nRead,
    input  logic [31:0] InstrData,
    output logic [7:0]  Opcode,
    output logic [7:0]  Dest,
    output logic [7:0]  Src1,
    output logic [7:0]  Src2,
    output logic        MatDispatch,
    output logic        IntDispatch,
    input  logic        MatDone,
    input  logic        IntDone,
    output logic [11:0] PC,
    output logic        Busy,
    output logic        Halted,
    output logic        IllegalOp
`ifdef SEQ_TIMEOUT_EN
    , output logic      Timeout
`endif
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_WMAT   = 3'd3;
    localparam logic [2:0] S_WINT   = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    localparam logic [11:0] LAST_PC = 12'(INSTR_DEPTH - 1);

    logic [2:0]  state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] fld_q, fld_d;
    logic        mat_q, mat_d, int_q, int_d;
    logic        done_ok;
    logic [7:0]  op;
`ifdef SEQ_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        tmo_q, tmo_d;
`endif

    assign op = ir_q[31:24];
    // A Done coinciding with the dispatch pulse belongs to a previous transaction and is dropped.
    assign done_ok = (state_q == S_WMAT && MatDone && !mat_q) ||
                     (state_q == S_WINT && IntDone && !int_q);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        fld_d   = fld_q;
        mat_d   = 1'b0;
        int_d   = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
`endif
        case (state_q)
            S_IDLE: if (Start) state_d = S_FETCH;
            S_FETCH: begin
                ir_d    = InstrData;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                fld_d = ir_q;
`ifdef SEQ_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (op <= 8'h07) begin
                    mat_d   = 1'b1;
                    state_d = S_WMAT;
                end else if (op >= 8'h10 && op <= 8'h13) begin
                    int_d   = 1'b1;
                    state_d = S_WINT;
                end else if (op == 8'hFF) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_ERROR;
                end
            end
            S_WMAT, S_WINT: begin
                if (done_ok) begin
                    if (pc_q == LAST_PC) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d    = pc_q + 12'd1;
                        state_d = S_FETCH;
                    end
                end
`ifdef SEQ_TIMEOUT_EN
                else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_ERROR;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            S_HALT, S_ERROR: begin
                if (Start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
`ifdef SEQ_TIMEOUT_EN
                    tmo_d   = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            fld_q   <= '0;
            mat_q   <= 1'b0;
            int_q   <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            fld_q   <= fld_d;
            mat_q   <= mat_d;
            int_q   <= int_d;
`ifdef SEQ_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign Address     = (state_q == S_FETCH) ? {INSTR_MEM_EN, pc_q} : 16'h0000;
    assign nRead       = (state_q != S_FETCH);
    assign {Opcode, Dest, Src1, Src2} = fld_q;
    assign MatDispatch = mat_q;
    assign IntDispatch = int_q;
    assign PC          = pc_q;
    assign Busy        = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                         (state_q == S_WMAT)  || (state_q == S_WINT);
    assign Halted      = (state_q == S_HALT);
    assign IllegalOp   = (state_q == S_ERROR);
`ifdef SEQ_TIMEOUT_EN
    assign Timeout     = tmo_q;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: random programs checked against a program-level reference model,
// plus directed reset, ignore-rule, illegal-opcode and watchdog scenarios.
module tb_instr_sequencer;
    localparam int DEPTH = 12;
`ifdef SEQ_TIMEOUT_EN
    localparam int MAXD = 6;
`else
    localparam int MAXD = 10;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [15:0] Address;
    logic        nRead;
    logic [31:0] InstrData = 32'h0;
    logic [7:0]  Opcode, Dest, Src1, Src2;
    logic        MatDispatch, IntDispatch;
    logic        MatDone = 1'b0;
    logic        IntDone = 1'b0;
    logic [11:0] PC;
    logic        Busy, Halted, IllegalOp;
`ifdef SEQ_TIMEOUT_EN
    logic        Timeout;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [0:DEPTH-1];

    typedef struct packed {
        logic        is_int;
        logic [11:0] pc;
        logic [31:0] w;
    } disp_t;

`ifdef SEQ_TIMEOUT_EN
    instr_sequencer #(.TIMEOUT_CYCLES(8)) dut (
`else
    instr_sequencer dut (
`endif
        .Clk(Clk), .Reset(Reset), .Start(Start), .Address(Address), .nRead(nRead),
        .InstrData(InstrData), .Opcode(Opcode), .Dest(Dest), .Src1(Src1), .Src2(Src2),
        .MatDispatch(MatDispatch), .IntDispatch(IntDispatch), .MatDone(MatDone),
        .IntDone(IntDone), .PC(PC), .Busy(Busy), .Halted(Halted), .IllegalOp(IllegalOp)
`ifdef SEQ_TIMEOUT_EN
        , .Timeout(Timeout)
`endif
    );

    always #5 Clk = ~Clk;

    // Instruction memory: updates on the falling edge while read is active, garbage otherwise.
    always @(negedge Clk) begin
        if (!nRead && Address[11:0] < 12'(DEPTH)) InstrData = mem[Address[3:0]];
        else InstrData = $urandom();
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] gen(input int kind);
        logic [7:0] op;
        case (kind)
            0: op = 8'($urandom_range(0, 7));
            1: op = 8'h10 + 8'($urandom_range(0, 3));
            2: op = 8'hFF;
            default: op = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(8, 15))
                                                      : 8'($urandom_range(8'h14, 8'hFE));
        endcase
        return {op, 24'($urandom())};
    endfunction

    task automatic do_reset();
        Reset = 1'b1; Start = 1'b0; MatDone = 1'b0; IntDone = 1'b0;
        @(negedge Clk); @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic wait_disp(input string tag);
        int n = 0;
        while (!(MatDispatch || IntDispatch) && n < 50) begin
            @(negedge Clk); n++;
        end
        chk(tag, 32'(MatDispatch || IntDispatch), 32'd1);
    endtask

    // Runs mem[] from PC 0 with random Done latencies and Done noise; expectations come from
    // walking the program image.
    task automatic run_program();
        disp_t q[$];
        disp_t e;
        logic [7:0] op;
        logic exp_halt = 1'b1;
        int exp_pc = DEPTH - 1, exp_fetch = DEPTH;
        int fidx = 0, cnt = 0;
        bit pending = 0, pend_int = 0, fired, fin = 0;
        for (int i = 0; i < DEPTH; i++) begin
            op = mem[i][31:24];
            if (op <= 8'h07 || (op >= 8'h10 && op <= 8'h13)) begin
                e.is_int = (op >= 8'h10); e.pc = 12'(i); e.w = mem[i];
                q.push_back(e);
            end else begin
                exp_halt = (op == 8'hFF); exp_pc = i; exp_fetch = i + 1;
                break;
            end
        end
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        chk("start_pc", 32'(PC), 32'd0);
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            chk("state_excl", 32'($onehot0({Busy, Halted, IllegalOp})), 32'd1);
            if (!nRead) begin
                chk("fetch_addr", 32'(Address), {16'h0, 4'h2, 12'(fidx)});
                fidx++;
            end else begin
                chk("idle_addr", 32'(Address), 32'd0);
            end
            MatDone = 1'b0; IntDone = 1'b0; fired = 0;
            if (MatDispatch || IntDispatch) begin
                chk("single_disp", 32'(MatDispatch & IntDispatch), 32'd0);
                chk("disp_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("disp_unit", 32'(IntDispatch), 32'(e.is_int));
                    chk("disp_fields", {Opcode, Dest, Src1, Src2}, e.w);
                    chk("disp_pc", 32'(PC), 32'(e.pc));
                end
                pending = 1; pend_int = IntDispatch;
                cnt = $urandom_range(1, MAXD);
                if ($urandom_range(0, 1) == 1) begin
                    if (pend_int) IntDone = 1'b1; else MatDone = 1'b1;
                end
            end else if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    if (pend_int) IntDone = 1'b1; else MatDone = 1'b1;
                    pending = 0; fired = 1;
                end
            end
            if (pending || fired) begin
                if (pend_int) MatDone = 1'($urandom_range(0, 1));
                else IntDone = 1'($urandom_range(0, 1));
            end else if (!(MatDispatch || IntDispatch)) begin
                MatDone = 1'($urandom_range(0, 1));
                IntDone = 1'($urandom_range(0, 1));
            end
            if (Halted || IllegalOp) fin = 1;
            else @(negedge Clk);
        end
        MatDone = 1'b0; IntDone = 1'b0;
        chk("prog_finished", 32'(fin), 32'd1);
        chk("disp_left", 32'(q.size()), 32'd0);
        chk("final_halted", 32'(Halted), 32'(exp_halt));
        chk("final_illegal", 32'(IllegalOp), 32'(!exp_halt));
        chk("final_pc", 32'(PC), 32'(exp_pc));
        chk("fetch_count", 32'(fidx), 32'(exp_fetch));
`ifdef SEQ_TIMEOUT_EN
        chk("no_timeout", 32'(Timeout), 32'd0);
`endif
    endtask

    initial begin
        int kinds[DEPTH];
        int n;
        int j;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hFF00_0000;

        // Reset state
        do_reset();
        chk("rst_addr", 32'(Address), 32'd0);
        chk("rst_nread", 32'(nRead), 32'd1);
        chk("rst_pc", 32'(PC), 32'd0);
        chk("rst_flags", {28'h0, Busy, Halted, IllegalOp, MatDispatch | IntDispatch}, 32'd0);
        chk("rst_fields", {Opcode, Dest, Src1, Src2}, 32'd0);

        // First instruction, step by step
        mem[0] = 32'h0302_0001;
        Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        chk("t1_fetch_addr", 32'(Address), 32'h2000);
        chk("t1_fetch_nread", 32'(nRead), 32'd0);
        @(negedge Clk);
        chk("t1_decode_nread", 32'(nRead), 32'd1);
        chk("t1_decode_nodisp", 32'(MatDispatch), 32'd0);
        @(negedge Clk);
        chk("t1_matdisp", 32'(MatDispatch), 32'd1);
        chk("t1_intdisp", 32'(IntDispatch), 32'd0);
        chk("t1_fields", {Opcode, Dest, Src1, Src2}, 32'h0302_0001);
        @(negedge Clk);
        chk("t1_pulse_end", 32'(MatDispatch), 32'd0);
        @(negedge Clk);
        @(negedge Clk); MatDone = 1'b1;
        @(negedge Clk); MatDone = 1'b0;
        chk("t1_next_addr", 32'(Address), 32'h2001);
        chk("t1_next_nread", 32'(nRead), 32'd0);
        chk("t1_next_pc", 32'(PC), 32'd1);

        // Full 12-word program: 8 matrix, 3 integer in shuffled order, FFh last
        do_reset();
        for (int i = 0; i < DEPTH - 1; i++) kinds[i] = 0;
        n = 0;
        while (n < 3) begin
            j = $urandom_range(0, DEPTH - 2);
            if (kinds[j] == 0) begin kinds[j] = 1; n++; end
        end
        kinds[DEPTH-1] = 2;
        for (int i = 0; i < DEPTH; i++) mem[i] = gen(kinds[i]);
        run_program();

        // All words valid: stops at end of memory (restart from HALT)
        for (int i = 0; i < DEPTH; i++) mem[i] = gen($urandom_range(0, 1));
        run_program();

        // Mixed random programs, each restarted from the previous HALT/ERROR
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                n = $urandom_range(0, 19);
                mem[i] = gen(n < 10 ? 0 : n < 17 ? 1 : n < 18 ? 2 : 3);
            end
            run_program();
        end

        // Non-matching Done ignored in WAIT_INT
        do_reset();
        mem[0] = 32'h1010_0A0B;
        Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        wait_disp("t3_disp_seen");
        chk("t3_intdisp", 32'(IntDispatch), 32'd1);
        chk("t3_fields", {Opcode, Dest, Src1, Src2}, 32'h1010_0A0B);
        repeat (3) begin @(negedge Clk); MatDone = 1'b1; end
        @(negedge Clk); MatDone = 1'b0;
        chk("t3_still_wait_pc", 32'(PC), 32'd0);
        chk("t3_still_busy", 32'(Busy & nRead), 32'd1);
        IntDone = 1'b1;
        @(negedge Clk); IntDone = 1'b0;
        chk("t3_pc_adv", 32'(PC), 32'd1);
        chk("t3_refetch", 32'(Address), 32'h2001);

        // Illegal opcode: sticky ERROR, restart refetches word 0
        do_reset();
        mem[0] = 32'h2A00_0000;
        run_program();
        repeat (5) @(negedge Clk);
        chk("t4_sticky", 32'(IllegalOp), 32'd1);
        chk("t4_not_busy", 32'(Busy), 32'd0);
        run_program();

        // Async reset in WAIT_MAT with a Done pending
        do_reset();
        mem[0] = 32'h0001_0203;
        mem[1] = 32'h0504_0506;
        Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        wait_disp("t5_disp0");
        @(negedge Clk); MatDone = 1'b1;
        @(negedge Clk); MatDone = 1'b0;
        wait_disp("t5_disp1");
        chk("t5_pc1", 32'(PC), 32'd1);
        @(negedge Clk); MatDone = 1'b1;
        #2 Reset = 1'b1;
        #1;
        chk("t5_rst_pc", 32'(PC), 32'd0);
        chk("t5_rst_nread", 32'(nRead), 32'd1);
        chk("t5_rst_busy", 32'(Busy), 32'd0);
        chk("t5_rst_fields", {Opcode, Dest, Src1, Src2}, 32'd0);
        @(negedge Clk); Reset = 1'b0;
        repeat (3) @(negedge Clk);
        MatDone = 1'b0;
        chk("t5_idle", 32'(Busy | Halted | IllegalOp), 32'd0);
        chk("t5_idle_pc", 32'(PC), 32'd0);

        // WAIT with no Done
        do_reset();
        mem[0] = 32'h0100_0000;
        Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        wait_disp("t6_disp");
`ifdef SEQ_TIMEOUT_EN
        repeat (7) @(negedge Clk);
        chk("t6_pre_err", 32'(IllegalOp), 32'd0);
        chk("t6_pre_busy", 32'(Busy), 32'd1);
        @(negedge Clk);
        chk("t6_err", 32'(IllegalOp), 32'd1);
        chk("t6_timeout", 32'(Timeout), 32'd1);
        Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        chk("t6_tmo_clr", 32'(Timeout | IllegalOp), 32'd0);
        chk("t6_refetch", 32'(Address), 32'h2000);
`else
        repeat (1000) @(negedge Clk);
        chk("t6_still_busy", 32'(Busy), 32'd1);
        chk("t6_still_wait", 32'(nRead & !Halted & !IllegalOp), 32'd1);
        chk("t6_pc", 32'(PC), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Fetch/dispatch controller for the SoC: walks instruction memory (unit select 2 on the shared bus) from word 0, decodes each 32-bit word (opcode::dest::src1::src2, 8 bits each), and hands it to the matrix ALU or the integer ALU over a dispatch/done handshake.
- Stops on opcode FFh, on end of memory, or on an illegal opcode.
- Sits between instruction memory and the two execution units; the units do their own operand/result bus traffic.

Parameters:
- INSTR_MEM_EN, 4'h2, unit select placed on Address[15:12] during fetch.
- INSTR_DEPTH, 12, number of instruction words; last valid PC is INSTR_DEPTH-1.
- TIMEOUT_CYCLES, 256, watchdog limit in cycles; used only with SEQ_TIMEOUT_EN.

Ports:
- Clk  in  1  system clock, rising-edge logic.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  level sampled in IDLE/HALT/ERROR; begins execution at PC 0.
- Address  out  16  {INSTR_MEM_EN, 12'(PC)} during FETCH, else 0.
- nRead  out  1  low only in FETCH.
- InstrData  in  32  instruction memory data; valid after the falling edge within FETCH.
- Opcode/Dest/Src1/Src2  out  8 each  decoded fields; held until the next DECODE.
- MatDispatch  out  1  one-cycle pulse; opcodes 00h–07h.
- IntDispatch  out  1  one-cycle pulse; opcodes 10h–13h.
- MatDone  in  1  matrix ALU completion.
- IntDone  in  1  integer ALU completion.
- PC  out  12  current instruction index.
- Busy  out  1  high in FETCH/DECODE/WAIT.
- Halted  out  1  high in HALT.
- IllegalOp  out  1  high in ERROR.
- Timeout  out  1  watchdog flag; exists only with SEQ_TIMEOUT_EN.

Behaviour:
- Reset (async, any state, including mid-dispatch):
  - state IDLE, PC 0, IR 0, Address 0, nRead 1;
  - all pulses and flags 0, field outputs 0.
- States and transitions:
  - IDLE: Start=1 → FETCH.
  - FETCH: lasts exactly 1 cycle. Drives Address and nRead=0; memory updates on the intervening negedge. Next posedge captures InstrData into IR → DECODE.
  - DECODE: 1 cycle. Fields are loaded from IR.
    - 00h–07h → MatDispatch=1 for the next cycle → WAIT_MAT.
    - 10h–13h → IntDispatch=1 for the next cycle → WAIT_INT.
    - FFh → HALT.
    - Any other opcode → ERROR.
  - WAIT_MAT / WAIT_INT: sample only the matching Done. A Done that is high in the same cycle as the dispatch pulse is ignored. On an accepted Done:
    - if PC == INSTR_DEPTH-1 → HALT (PC unchanged);
    - else PC += 1 → FETCH.
  - HALT and ERROR: sticky. Start=1 → PC 0, flags cleared, then FETCH.
- Latency: Start high at edge N gives FETCH during N..N+1, DECODE at N+1..N+2, and the dispatch pulse in cycle N+2..N+3. A Done accepted at edge M gives the next FETCH in cycle M..M+1.
- Ignored inputs:
  - the non-matching Done, and any Done outside WAIT states;
  - Start while Busy.
- PC never wraps; InstrData outside FETCH capture is ignored.
- Busy, Halted and IllegalOp are mutually exclusive and decoded from state.

Optional Feature:
- SEQ_TIMEOUT_EN defined:
  - a 16-bit counter clears on entry to WAIT_* and increments each cycle in WAIT_*;
  - when it reaches TIMEOUT_CYCLES with no accepted Done → ERROR, Timeout=1;
  - Timeout and IllegalOp clear on restart.
- Undefined: no counter and no Timeout port; WAIT_* waits indefinitely.

Test Plan:
- Reset then Start, memory word0=03020001h, MatDone 3 cycles after the pulse → Address=2000h with nRead low for one cycle; Opcode=03h, Dest=02h, Src1=00h, Src2=01h; one MatDispatch pulse; PC=1 and a new FETCH at Address=2001h.
- Full default 12-word program with each Done after a random delay of 1–10 cycles → 11 dispatches (8 Mat, 3 Int, in program order), then Halted=1 with PC=11 and no dispatch for FFh.
- word0=10100A0Bh, MatDone pulsed in WAIT_INT → ignored; IntDone → PC advances to 1.
- word0=2A000000h → IllegalOp=1, no dispatch, stays in ERROR; Start → PC 0 and refetch of 2000h.
- Reset asserted in WAIT_MAT with a pending MatDone → immediate IDLE, PC 0, nRead 1; the later MatDone is ignored.
- With SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8 and no Done → ERROR with Timeout=1 after 8 WAIT cycles. Without the macro, the sequencer is still in WAIT after 1000 cycles.
